// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter states and baud defaults
// for uart_tx / uart_rx and the transmit arbiter.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int BAUD_RATE   = 9600;
  localparam int CLOCK_FREQ  = 38400000;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; master is the
// producer/uart_tx side, slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_valid;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_ready;
  logic                           gnt_valid;
  logic [2:0]                     gnt_id;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_valid,
    input  tx_data,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_valid,
    output tx_data,
    output gnt_valid,
    output gnt_id
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NUM_REQ-1.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         idx,
  output logic               any
);

  logic [7:0] req8;
  logic [3:0] j;

  // Scan from the far end so the closest candidate to ptr wins last.
  always_comb begin
    req8 = '0;
    req8[NUM_REQ-1:0] = req;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + 4'(i);
      if (j >= 4'(NUM_REQ)) begin
        j = j - 4'(NUM_REQ);
      end
      if (req8[j[2:0]]) begin
        idx = j[2:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ
// byte streams. Optional mid-packet idle timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BYTES      = 64,
  parameter int TIMEOUT_CYCLES = 38400
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic              timeout_pulse
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      MAX_BYTES < 1 || MAX_BYTES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t state;
  arb_state_t state_nxt;

  logic [2:0] rr_ptr;
  logic [2:0] gnt_id;
  logic [2:0] ptr_nxt;
  logic [2:0] pick_idx;
  logic       pick_any;
  logic [7:0] byte_cnt;

  logic [7:0]                        vld8;
  logic [7:0]                        lst8;
  logic [7:0]                        rdy8;
  logic [7:0][UART_BYTE_W-1:0]       dat8;

  logic xfer;
  logic hit_cap;
  logic idle_hit;
  logic release_lock;

  // Pad per-requester vectors to 8 so a 3-bit grant index is always legal.
  always_comb begin
    vld8 = '0;
    lst8 = '0;
    dat8 = '0;
    vld8[NUM_REQ-1:0] = bus.req_valid;
    lst8[NUM_REQ-1:0] = bus.req_last;
    for (int i = 0; i < NUM_REQ; i++) begin
      dat8[i] = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ptr_nxt = (gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_id + 3'd1;
  assign xfer    = (state == LOCK) && vld8[gnt_id] && bus.tx_ready;
  assign hit_cap = ({1'b0, byte_cnt} + 9'd1) == 9'(MAX_BYTES);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign idle_hit = (state == LOCK) && !vld8[gnt_id] &&
                    (({1'b0, idle_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
  assign timeout_pulse = idle_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != LOCK || xfer) begin
      idle_cnt <= '0;
    end else if (!vld8[gnt_id]) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  assign release_lock = (xfer && (lst8[gnt_id] || hit_cap)) || idle_hit;

  always_comb begin
    state_nxt    = state;
    rdy8         = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        bus.tx_valid = vld8[gnt_id];
        bus.tx_data  = vld8[gnt_id] ? dat8[gnt_id] : '0;
        rdy8[gnt_id] = bus.tx_ready;
        if (release_lock) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    bus.req_ready = rdy8[NUM_REQ-1:0];
  end

  assign bus.gnt_valid = (state == LOCK);
  assign bus.gnt_id    = gnt_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        gnt_id   <= pick_idx;
        byte_cnt <= '0;
      end else if (state == LOCK) begin
        if (xfer && byte_cnt != 8'hFF) begin
          byte_cnt <= byte_cnt + 8'd1;
        end
        if (release_lock) begin
          rr_ptr <= ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based arbitration model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef UART_ARB_TIMEOUT_EN
  logic tp;
`endif

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .MAX_BYTES      (MAXB),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_pulse (tp)
`endif
  );

  logic [8:0] mem [N][256];
  int         hd [N];
  int         tl [N];

  logic [N-1:0] vin, lin, pause, hold;
  logic [7:0]   din [N];
  logic         txr;
  logic         rdyq [$];
  bit           rdy_rand;

  bit m_lock;
  int m_g, m_ptr, m_cnt;
  int n_cmp, n_err, m_xfers, d_xfers, pushed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    mem[r][tl[r]] = {last, d};
    tl[r]++;
    pushed++;
  endtask

  task automatic push_pkt(input int r, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      push_byte(r, 8'($urandom), with_last && (k == len - 1));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hd[i] != tl[i] && !pause[i]) begin
        vin[i] = 1'b1;
        {lin[i], din[i]} = mem[i][hd[i]];
      end else begin
        vin[i] = 1'b0;
        lin[i] = 1'($urandom % 2);
        din[i] = 8'($urandom);
      end
      bus.req_data[8*i +: 8] = din[i];
    end
    if (rdyq.size() != 0) txr = rdyq.pop_front();
    else if (rdy_rand) txr = ($urandom % 4) != 0;
    else txr = 1'b1;
    bus.req_valid = vin;
    bus.req_last  = lin;
    bus.tx_ready  = txr;
  endtask

  task automatic check_update();
    logic         ev;
    logic [7:0]   ed;
    logic [N-1:0] er;
    int           pi;
    bit           found;
    ev = 1'b0; ed = '0; er = '0; pi = -1; found = 0;
    if (m_lock) begin
      ev = vin[m_g];
      ed = ev ? din[m_g] : 8'h00;
      if (txr) er[m_g] = 1'b1;
    end
    chk("tx_valid",  32'(bus.tx_valid),  32'(ev));
    chk("tx_data",   32'(bus.tx_data),   32'(ed));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_lock));
    if (m_lock) chk("gnt_id", 32'(bus.gnt_id), 32'(m_g));
    if (bus.tx_valid && txr) d_xfers++;
    if (!m_lock) begin
      if (vin != '0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && vin[(m_ptr + k) % N]) begin
            m_g = (m_ptr + k) % N;
            found = 1;
          end
        end
        m_lock = 1;
        m_cnt  = 0;
      end
    end else if (vin[m_g] && txr) begin
      hd[m_g]++;
      pi = m_g;
      m_cnt++;
      m_xfers++;
      if (lin[m_g] || m_cnt == MAXB) begin
        m_lock = 0;
        m_ptr  = (m_g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) hold[i] = vin[i] && (pi != i);
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_update();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lock = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    hold   = '0;
  endtask

  task automatic reset_sync();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit busy();
    bit b;
    b = m_lock;
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) b = 1;
    return b;
  endfunction

  task automatic drain(input string tag);
    int k;
    k = 0;
    pause = '0;
    while (busy() && k < 2000) begin
      step();
      k++;
    end
    chk(tag, 32'(busy()), 32'(0));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_xfers = 0; d_xfers = 0; pushed = 0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    pause = '0; rdy_rand = 0;
    model_reset();
    rst = 1'b1;
    drive();
    #2;
    chk("rst_tx_valid",  32'(bus.tx_valid),  32'(0));
    chk("rst_tx_data",   32'(bus.tx_data),   32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'(0));
    chk("rst_gnt_id",    32'(bus.gnt_id),    32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester, three bytes.
    push_byte(0, 8'hA5, 0);
    push_byte(0, 8'h5A, 0);
    push_byte(0, 8'h3C, 1);
    drain("single_done");

    // Contention from reset, then again with pointer at 3.
    reset_sync();
    push_pkt(0, 2, 1);
    push_pkt(2, 2, 1);
    drain("contend_done");
    push_pkt(2, 2, 1);
    push_pkt(0, 2, 1);
    drain("contend2_done");

    // Cap release and re-grant, then lock held while holder is silent.
    reset_sync();
    push_pkt(1, 6, 0);
    for (int k = 0; k < 10; k++) step();
    push_pkt(0, 1, 1);
    for (int k = 0; k < 4; k++) step();
    reset_sync();
    drain("after_cap_done");

    // Backpressure during a two-byte packet.
    push_pkt(3, 2, 1);
    rdyq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drain("bp_done");

    // Asynchronous reset after the first of three bytes.
    reset_sync();
    push_pkt(1, 3, 1);
    push_pkt(3, 2, 1);
    step();
    step();
    drive();
    #2;
    chk("pre_rst_lock", 32'(bus.gnt_valid), 32'(m_lock));
    rst = 1'b1;
    #1;
    chk("arst_tx_valid",  32'(bus.tx_valid),  32'(0));
    chk("arst_tx_data",   32'(bus.tx_data),   32'(0));
    chk("arst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("arst_gnt_valid", 32'(bus.gnt_valid), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain("arst_done");

    // Random traffic with stalls and mid-packet valid drops.
    rdy_rand = 1;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++) begin
        if (tl[r] - hd[r] < 4 && tl[r] < 240 && ($urandom % 8) == 0)
          push_pkt(r, 1 + int'($urandom % 6), 1);
        pause[r] = hold[r] ? 1'b0 : (($urandom % 5) == 0);
      end
      step();
    end
    rdy_rand = 0;
    drain("rand_done");

    chk("xfer_count", 32'(d_xfers), 32'(m_xfers));
    chk("all_bytes",  32'(m_xfers), 32'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
